// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared widths and one-hot loader state encoding
package operand_loader_pkg;
  localparam int DATA_W = 8;
  localparam int TILE = 4;
  localparam int ADDR_W = 8;
  localparam int LOC_W = 4;
  localparam int GLB_W = 4;
  localparam int DIM_W = 4;
  localparam int WORD_W = TILE * DATA_W;
  localparam int TILE_W = TILE * WORD_W;
  localparam int IDX_W = GLB_W + 2;
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    FETCH = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: operand SRAM read port (en/addr out, rdata one cycle later)
interface operand_loader_if;
  import operand_loader_pkg::*;
  logic en;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] rdata;
  modport master(output en, addr, input rdata);
  modport slave(input en, addr, output rdata);
endinterface

// File: rtl/operand_loader_tile_mask.sv
// operand_loader_tile_mask: zero bytes beyond the m/n bound and words beyond k
module operand_loader_tile_mask
  import operand_loader_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [GLB_W-1:0]  blk,
  input  logic [LOC_W-1:0]  loc,
  input  logic [1:0]        j,
  input  logic [DIM_W-1:0]  bound,
  input  logic [DIM_W-1:0]  k,
  output logic [WORD_W-1:0] masked
);
  logic k_ok;
  assign k_ok = {loc, j} < IDX_W'(k);
  for (genvar r = 0; r < TILE; r++) begin : g_byte
    assign masked[r*DATA_W +: DATA_W] = (k_ok && {blk, 2'(r)} < IDX_W'(bound)) ? word[r*DATA_W +: DATA_W] : '0;
  end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: fetch one masked 4x4 A or B tile per controller command
module operand_loader
  import operand_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               dp_cnt_rst,
  input  logic               cmd_read_a,
  input  logic               cmd_read_b,
  input  logic [DIM_W-1:0]   m,
  input  logic [DIM_W-1:0]   n,
  input  logic [DIM_W-1:0]   k,
  input  logic [LOC_W-1:0]   blk_local_idx,
  input  logic [GLB_W-1:0]   a_blk_idx,
  input  logic [GLB_W-1:0]   b_blk_idx,
  operand_loader_if.master   a_mem,
  operand_loader_if.master   b_mem,
  output logic [TILE_W-1:0]  a_tile,
  output logic [TILE_W-1:0]  b_tile,
  output logic               int_read_a,
  output logic               int_read_b
);
  state_t state;
  logic sel, en_a, en_b, rv;
  logic [1:0] cnt, ri;
  logic [ADDR_W-1:0] addr;
  logic [DIM_W-1:0] bound_l, k_l;
  logic [GLB_W-1:0] blk_l, blk_in;
  logic [LOC_W-1:0] loc_l;
  logic [WORD_W-1:0] masked;
  assign blk_in = cmd_read_a ? a_blk_idx : b_blk_idx;
  assign a_mem.en = en_a;
  assign b_mem.en = en_b;
  assign a_mem.addr = addr;
  assign b_mem.addr = addr;
  operand_loader_tile_mask u_mask (
    .word  (sel ? b_mem.rdata : a_mem.rdata),
    .blk   (blk_l),
    .loc   (loc_l),
    .j     (ri),
    .bound (bound_l),
    .k     (k_l),
    .masked
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= 1'b0;
      en_a <= 1'b0;
      en_b <= 1'b0;
      rv <= 1'b0;
      cnt <= '0;
      ri <= '0;
      addr <= '0;
      bound_l <= '0;
      k_l <= '0;
      blk_l <= '0;
      loc_l <= '0;
      a_tile <= '0;
      b_tile <= '0;
      int_read_a <= 1'b0;
      int_read_b <= 1'b0;
    end else begin
      rv <= en_a | en_b;
      ri <= cnt;
      int_read_a <= 1'b0;
      int_read_b <= 1'b0;
      if (rv && sel) b_tile[ri*WORD_W +: WORD_W] <= masked;
      if (rv && !sel) a_tile[ri*WORD_W +: WORD_W] <= masked;
      if (dp_cnt_rst) begin
        state <= IDLE;
        cnt <= '0;
        en_a <= 1'b0;
        en_b <= 1'b0;
        rv <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cmd_read_a || cmd_read_b) begin
            state <= FETCH;
            sel <= !cmd_read_a;
            en_a <= cmd_read_a;
            en_b <= !cmd_read_a;
            cnt <= '0;
            addr <= ADDR_W'(blk_in) * ADDR_W'(k) + ADDR_W'({blk_local_idx, 2'b00});
            bound_l <= cmd_read_a ? m : n;
            k_l <= k;
            blk_l <= blk_in;
            loc_l <= blk_local_idx;
          end
          FETCH: begin
            cnt <= cnt + 2'd1;
            addr <= addr + ADDR_W'(1);
            if (cnt == 2'd3) begin
              state <= DRAIN;
              en_a <= 1'b0;
              en_b <= 1'b0;
            end
          end
          DRAIN: begin
            state <= DONE;
            int_read_a <= !sel;
            int_read_b <= sel;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: table-driven scoreboard bench for operand_loader
module tb_operand_loader;
  import operand_loader_pkg::*;
  typedef struct {
    logic b;
    logic [3:0] m, n, k, loc, ga, gb;
    logic [7:0] a0;
  } vec_t;
  typedef struct {
    logic b;
    logic [7:0] addr;
    int cyc;
  } beat_t;
  typedef struct {
    logic b;
    int cyc;
    logic [127:0] a, bt;
  } done_t;
  logic clk = 1'b0, reset = 1'b1, dp_cnt_rst = 1'b0, cmd_read_a = 1'b0, cmd_read_b = 1'b0;
  logic [3:0] m = '0, n = '0, k = '0, blk_local_idx = '0, a_blk_idx = '0, b_blk_idx = '0;
  logic [127:0] a_tile, b_tile, exp_a = '0, exp_b = '0;
  logic int_read_a, int_read_b;
  int cyc = 0, checks = 0, errors = 0;
  beat_t beat_q[$];
  done_t done_q[$];
  vec_t vecs[8];
  operand_loader_if a_mem();
  operand_loader_if b_mem();
  operand_loader dut (
    .clk, .reset, .dp_cnt_rst, .cmd_read_a, .cmd_read_b,
    .m, .n, .k, .blk_local_idx, .a_blk_idx, .b_blk_idx,
    .a_mem(a_mem), .b_mem(b_mem),
    .a_tile, .b_tile, .int_read_a, .int_read_b
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mem_word(input logic b, input logic [7:0] addr);
    logic [31:0] w;
    for (int r = 0; r < 4; r++) w[r*8 +: 8] = (b ? 8'h80 : 8'h00) + addr + 8'(r + 1);
    return w;
  endfunction
  always @(posedge clk) begin
    a_mem.rdata <= a_mem.en ? mem_word(1'b0, a_mem.addr) : 32'hDEADBEEF;
    b_mem.rdata <= b_mem.en ? mem_word(1'b1, b_mem.addr) : 32'hDEADBEEF;
  end
  function automatic logic [127:0] model(input vec_t v);
    logic [127:0] t;
    logic [31:0] w;
    int g, bound;
    t = '0;
    g = v.b ? int'(v.gb) : int'(v.ga);
    bound = v.b ? int'(v.n) : int'(v.m);
    for (int j = 0; j < 4; j++) begin
      w = mem_word(v.b, 8'((g * int'(v.k) + int'(v.loc) * 4 + j) % 256));
      for (int r = 0; r < 4; r++)
        if (g * 4 + r < bound && int'(v.loc) * 4 + j < int'(v.k)) t[j*32 + r*8 +: 8] = w[r*8 +: 8];
    end
    return t;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push_beats(input logic b, input logic [7:0] a0, input int t, input int cnt);
    beat_t e;
    for (int j = 0; j < cnt; j++) begin
      e.b = b;
      e.addr = a0 + 8'(j);
      e.cyc = t + 1 + j;
      beat_q.push_back(e);
    end
  endtask
  task automatic push_done(input logic b, input int tc);
    done_t e;
    e.b = b;
    e.cyc = tc;
    e.a = exp_a;
    e.bt = exp_b;
    done_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (a_mem.en || b_mem.en) begin
      if (beat_q.size() == 0) chk("en_unexpected", {a_mem.en, b_mem.en}, 0);
      else begin
        beat_t e;
        e = beat_q.pop_front();
        chk("beat_en", {a_mem.en, b_mem.en}, e.b ? 2'b01 : 2'b10);
        chk("beat_addr", e.b ? b_mem.addr : a_mem.addr, e.addr);
        chk("beat_cycle", cyc, e.cyc);
      end
    end
    if (int_read_a || int_read_b) begin
      if (done_q.size() == 0) chk("int_unexpected", {int_read_a, int_read_b}, 0);
      else begin
        done_t e;
        e = done_q.pop_front();
        chk("int_sel", {int_read_a, int_read_b}, e.b ? 2'b01 : 2'b10);
        chk("int_cycle", cyc, e.cyc);
        chk("a_tile", a_tile, e.a);
        chk("b_tile", b_tile, e.bt);
      end
    end
  end
  task automatic drive(input vec_t v);
    m = v.m;
    n = v.n;
    k = v.k;
    blk_local_idx = v.loc;
    a_blk_idx = v.ga;
    b_blk_idx = v.gb;
  endtask
  task automatic scramble();
    m = 4'($urandom);
    n = 4'($urandom);
    k = 4'($urandom);
    blk_local_idx = 4'($urandom);
    a_blk_idx = 4'($urandom);
    b_blk_idx = 4'($urandom);
  endtask
  task automatic run_cmd(input vec_t v);
    int t;
    @(posedge clk); #1;
    drive(v);
    cmd_read_a = !v.b;
    cmd_read_b = v.b;
    t = cyc;
    push_beats(v.b, v.a0, t, 4);
    if (v.b) exp_b = model(v);
    else exp_a = model(v);
    push_done(v.b, t + 6);
    @(posedge clk); #1;
    cmd_read_a = 1'b0;
    cmd_read_b = 1'b0;
    scramble();
    repeat (6) @(posedge clk);
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_a_tile"}, a_tile, 0);
    chk({nm, "_b_tile"}, b_tile, 0);
    chk({nm, "_ctl"}, {a_mem.en, b_mem.en, int_read_a, int_read_b}, 0);
    chk({nm, "_addr"}, {a_mem.addr, b_mem.addr}, 0);
  endtask
  task automatic quiet(input string nm, input int n_cyc);
    repeat (n_cyc) begin
      @(negedge clk);
      chk(nm, {a_mem.en, b_mem.en, int_read_a, int_read_b}, 0);
    end
  endtask
  initial begin
    vec_t v;
    int t;
    vecs[0] = '{1'b0, 4'd4, 4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 8'd0};
    vecs[1] = '{1'b0, 4'd6, 4'd4, 4'd5, 4'd1, 4'd1, 4'd0, 8'd9};
    vecs[2] = '{1'b1, 4'd4, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 8'd0};
    vecs[3] = '{1'b0, 4'd15, 4'd15, 4'd15, 4'd3, 4'd3, 4'd2, 8'd57};
    vecs[4] = '{1'b1, 4'd9, 4'd5, 4'd7, 4'd1, 4'd2, 4'd1, 8'd11};
    vecs[5] = '{1'b0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 8'd29};
    vecs[6] = '{1'b1, 4'd2, 4'd15, 4'd15, 4'd2, 4'd0, 4'd3, 8'd53};
    vecs[7] = '{1'b1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 8'd0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);
    v = '{1'b0, 4'd5, 4'd6, 4'd8, 4'd1, 4'd0, 4'd1, 8'd4};
    @(posedge clk); #1;
    drive(v);
    cmd_read_a = 1'b1;
    cmd_read_b = 1'b1;
    t = cyc;
    push_beats(1'b0, 8'd4, t, 4);
    exp_a = model(v);
    push_done(1'b0, t + 6);
    repeat (6) @(posedge clk);
    #1 cmd_read_a = 1'b0;
    v.b = 1'b1;
    push_beats(1'b1, 8'd12, t + 7, 4);
    exp_b = model(v);
    push_done(1'b1, t + 13);
    @(posedge clk);
    @(posedge clk); #1;
    cmd_read_b = 1'b0;
    scramble();
    repeat (6) @(posedge clk);
    v = vecs[0];
    v.ga = 4'd1;
    @(posedge clk); #1;
    drive(v);
    cmd_read_a = 1'b1;
    t = cyc;
    push_beats(1'b0, 8'd4, t, 3);
    @(posedge clk); #1;
    cmd_read_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dp_cnt_rst = 1'b1;
    @(posedge clk); #1;
    dp_cnt_rst = 1'b0;
    quiet("abort_quiet", 6);
    run_cmd(vecs[1]);
    @(posedge clk); #1;
    drive(vecs[0]);
    cmd_read_a = 1'b1;
    t = cyc;
    push_beats(1'b0, 8'd0, t, 2);
    @(posedge clk); #1;
    cmd_read_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_a = '0;
    exp_b = '0;
    @(negedge clk);
    check_zero("mid_reset");
    quiet("reset_quiet", 6);
    chk("reset_a_tile_held", a_tile, 0);
    run_cmd(vecs[2]);
    repeat (2) @(posedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("ints_left", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Operand-fetch stage directly downstream of the matrix-multiply controller.
- Acts on the controller's READ_A and READ_B commands. For each command it fetches one 4x4 tile of A or B from its operand SRAM and zero-pads entries outside the m/k/n bounds.
- Holds each tile in a register buffer for the systolic feeder.
- Returns one-cycle completion interrupts (INT_READ_A / INT_READ_B) to the controller.

Parameters:
- DATA_W, 8: element width in bits.
- TILE, 4: tile edge; fixed at 4 to match the controller's block counting.
- ADDR_W, 8: SRAM word-address width.
- LOC_W, 4: width of blk_local_idx (equals `LOC_CNT_W).
- GLB_W, 4: width of a_blk_idx / b_blk_idx (equals `GLB_CNT_W).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- dp_cnt_rst  in  1  abort; returns the FSM to IDLE and clears counters next edge. Tile buffers are kept.
- cmd_read_a  in  1  start an A-tile fetch (level; sampled only in IDLE).
- cmd_read_b  in  1  start a B-tile fetch (level; sampled only in IDLE).
- m, n, k  in  4 each  matrix dimensions, 1..15; A is m x k, B is k x n.
- blk_local_idx  in  LOC_W  k-direction tile index.
- a_blk_idx  in  GLB_W  m-direction tile index.
- b_blk_idx  in  GLB_W  n-direction tile index.
- a_mem_en  out  1  A SRAM read enable.
- a_mem_addr  out  ADDR_W  A SRAM address.
- a_mem_rdata  in  TILE*DATA_W  A SRAM data, valid one cycle after a_mem_en.
- b_mem_en, b_mem_addr, b_mem_rdata  same as the A SRAM ports, for B.
- a_tile  out  TILE*TILE*DATA_W  A buffer; word j occupies bits [j*32 +: 32] and holds column j.
- b_tile  out  TILE*TILE*DATA_W  B buffer; word j holds row j.
- int_read_a  out  1  one-cycle pulse: A tile complete.
- int_read_b  out  1  one-cycle pulse: B tile complete.

Behaviour:
- Reset values: all outputs 0, tile buffers 0, FSM in IDLE, counters 0. Reset is applied synchronously at the clk edge.
- Memory layout:
  - A word addr = a_blk_idx*k + blk_local_idx*4 + j. Byte r of the word = A[a_blk_idx*4 + r][blk_local_idx*4 + j].
  - B word addr = b_blk_idx*k + blk_local_idx*4 + j. Byte c of the word = B[blk_local_idx*4 + j][b_blk_idx*4 + c].
  - j runs 0..3. Address arithmetic is done in ADDR_W bits and wraps modulo 2^ADDR_W.
- Index latching: m, n, k and all indices are latched at command acceptance and held until DONE. Input changes mid-fetch have no effect.
- Masking, A: byte r is forced to 0 if a_blk_idx*4 + r >= m. The whole word is forced to 0 if blk_local_idx*4 + j >= k.
- Masking, B: byte c is forced to 0 if b_blk_idx*4 + c >= n. The whole word is forced to 0 if blk_local_idx*4 + j >= k.
- Masked words are still read from SRAM; this keeps the timing fixed.
- FSM states: IDLE, FETCH, DRAIN, DONE. A one-bit sel records A or B.
  - IDLE: if cmd_read_a, go to FETCH with sel=A. Else if cmd_read_b, go to FETCH with sel=B. A has priority when both are high.
  - FETCH: issue en/addr for j = cnt, then cnt++. After cnt=3, go to DRAIN. Data for word cnt-1 is captured on each edge where a read was outstanding.
  - DRAIN: capture word 3, then go to DONE.
  - DONE: pulse int_read_a or int_read_b (matching sel) for exactly one cycle, then go to IDLE.
- Latency: command seen in IDLE at cycle t; en asserted at t+1..t+4; int pulse at t+6. The tile is stable and fully updated by t+6.
- Re-trigger: if the command is still high when the FSM returns to IDLE (t+7), a new fetch starts. The controller is responsible for dropping the command.
- The unselected tile buffer is never written.
- dp_cnt_rst in any state: the next state is IDLE, cnt=0, and no int is issued. If it coincides with DONE, the int pulse of that cycle still fires.
- Reset mid-fetch: returns to IDLE and clears the buffers. Any SRAM data arriving afterwards is ignored.

Decomposition:
- Shared constants go in def.v: TILE, DATA_W, INT/CMD bit positions, and the loader state encoding (one-hot, 4 bits).
- One sub-module, tile_mask: purely combinational. Inputs are the word, the row/column base, j, and the bounds; output is the masked word. It is instantiated once and shared between A and B via sel.

Test Plan:
- A fetch, m=k=n=4, all indices 0, SRAM A word w = {w+4, w+3, w+2, w+1}; pulse cmd_read_a at t → a_mem_en at t+1..t+4 with addr 0..3; int_read_a only at t+6; a_tile word j equals the SRAM word at addr j.
- Masking, m=6, k=5, a_blk_idx=1, blk_local_idx=1 → addrs 9..12; bytes 2 and 3 of every word are 0; words 1..3 are entirely 0.
- B fetch, n=3, k=4, b_blk_idx=0 → addrs 0..3; byte 3 of each word is 0; int_read_b at t+6; a_tile unchanged.
- cmd_read_a and cmd_read_b high together → A is fetched first. With both still high, B is not started until the A pulse is complete and B alone is asserted.
- dp_cnt_rst asserted at t+3 → no int pulse; FSM back in IDLE at t+4; a subsequent command completes normally with latency 6.
- reset asserted at t+2 for one cycle → all outputs and buffers 0 on the next edge; no int is issued.
